mem_arbiter: RTL
================

# mem_arbiter

Two-port-to-one memory arbiter for the 5-stage MIPS core. It shares a single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). It serialises requests through a small grant FSM and returns each response to its owner. It drives per-port stall flags that the hazard unit consumes to freeze the pipeline while a port waits.

## Interface
Parameters:
- TIMEOUT_W, 8: width of the wait counter; the `mem_err` flag fires after 2^TIMEOUT_W−1 cycles without `mem_ready`.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ireq_valid  in  1  fetch read request; held until `iresp_valid`
- ireq_addr  in  32  fetch address (u32); stable while valid
- iresp_valid  out  1  one-cycle pulse: instruction data valid
- iresp_data  out  32  instruction word
- dreq_valid  in  1  data request; held until `dresp_valid`
- dreq_write  in  1  1 = store, 0 = load
- dreq_addr  in  32  data address
- dreq_wdata  in  32  store data (word_t)
- dresp_valid  out  1  one-cycle pulse: data access complete
- dresp_data  out  32  load data (word_t)
- mem_valid  out  1  request to memory
- mem_write  out  1  write enable to memory
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  32  memory read data, valid with `mem_ready`
- istall  out  1  `ireq_valid && !iresp_valid`
- dstall  out  1  `dreq_valid && !dresp_valid`
- mem_err  out  1  sticky: wait counter saturated; cleared only by reset

## Operation
- FSM states: IDLE, IBUS, DBUS.
- IDLE:
  - No valid request: stay in IDLE.
  - Otherwise pick an owner, register `mem_addr`, `mem_write` and `mem_wdata` from that requester, and go to the owner's state. Instruction grants always register `mem_write` = 0.
- IBUS/DBUS:
  - `mem_valid` = 1.
  - Registered request fields are held constant.
  - In the cycle `mem_ready` = 1: pulse the owner's resp_valid with resp_data = `mem_rdata` (combinational pass-through), then return to IDLE.
- Priority, default: data over instruction, because the memory-stage instruction is older.
- Wait counter:
  - Cleared on every grant; increments each busy cycle without `mem_ready`.
  - At all-ones it sets `mem_err`. The FSM keeps waiting; it does not abort.
- Reset values: state IDLE; all outputs 0; `mem_addr`/`mem_wdata` 0; counter 0; `mem_err` 0; last-grant = instruction.

## Timing
- Grant latency: a request seen in IDLE at cycle t produces `mem_valid` at t+1.
- Response at cycle k, when `mem_ready` = 1. The FSM is in IDLE at k+1, so the earliest next `mem_valid` is k+2. Minimum of 2 cycles per access with zero-wait memory.
- Requesters may drop valid, or present a new request, at k+1. A still-asserted valid at k+1 is treated as a new request.
- `mem_ready` outside IBUS/DBUS is ignored.
- Simultaneous `ireq_valid` and `dreq_valid` in IDLE: arbitration rule applies. The loser is served on the next IDLE.
- A request arriving while busy waits; its stall stays high.
- Reset mid-access: the FSM returns to IDLE and `mem_valid` = 0 next cycle. No response is emitted. The memory side is also reset.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, grant the port not granted last. The last-grant flop updates on each grant.
- Undefined: fixed data-over-instruction priority. The last-grant flop is not built.

## Structure
- Add to the `pipes` package: `arb_state_t` enum (IDLE, IBUS, DBUS) and `arb_owner_t` enum (OWN_I, OWN_D).
- One sub-module, `arb_select`: combinational picker taking both valids plus last-grant, returning grant-valid plus owner. It holds the `ARB_ROUND_ROBIN_EN` choice.

## Test plan
- Single load, memory ready after 3 wait cycles:
  - Stimulus: dreq addr 0x100, `mem_rdata` 0xDEADBEEF.
  - Required: `mem_valid` for 4 cycles; one `dresp_valid` pulse with 0xDEADBEEF; `dstall` high until the pulse.
- Simultaneous requests, fixed priority:
  - Stimulus: ireq 0x0 and dreq store 0x200/0x55.
  - Required: store issued first with `mem_write` = 1; fetch issued 2 cycles after the store's `mem_ready`.
- Round-robin on, continuous contention from both ports:
  - Required: grants alternate D, I, D, I.
- Back-to-back fetches 0x0, 0x4, 0x8 with zero-wait memory:
  - Required: responses every 2 cycles with correct data order.
- Reset asserted while in DBUS:
  - Required: IDLE and `mem_valid` = 0 the next cycle; no `dresp_valid`.
- Memory never ready, TIMEOUT_W = 4:
  - Required: `mem_err` set after 15 busy cycles and stays set until reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline types for the memory arbiter: grant FSM states and port owners.
package pipes;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Combinational requester picker for mem_arbiter.
// ARB_ROUND_ROBIN_EN: on contention grant the port not granted last;
// otherwise data always beats instruction (the memory-stage op is older).
module arb_select
    import pipes::*;
(
    input  logic       ivalid,
    input  logic       dvalid,
    input  arb_owner_t last_owner,
    output logic       grant_valid,
    output arb_owner_t owner
);

    // Pick the owner for a grant taken this cycle.
    always_comb begin
        grant_valid = ivalid | dvalid;
        owner       = OWN_I;
        if (dvalid && !ivalid) begin
            owner = OWN_D;
        end else if (dvalid && ivalid) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
            owner = OWN_D;
`endif
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the grant history.
    logic unused_last;
    assign unused_last = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data to unified memory port arbiter for the 5-stage MIPS core.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating grants on contention.
module mem_arbiter
    import pipes::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_addr,
    output logic        iresp_valid,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic        dreq_write,
    input  logic [31:0] dreq_addr,
    input  logic [31:0] dreq_wdata,
    output logic        dresp_valid,
    output logic [31:0] dresp_data,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        istall,
    output logic        dstall,
    output logic        mem_err
);

    // Counter value one short of saturation; the step from here sets mem_err.
    localparam logic [TIMEOUT_W-1:0] CNT_PRESAT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    arb_state_t           state;
    arb_state_t           state_next;
    arb_owner_t           grant_owner;
    arb_owner_t           last_owner;
    logic                 grant_valid;
    logic                 grant;
    logic                 busy;
    logic [TIMEOUT_W-1:0] wait_cnt;

    arb_select u_select (
        .ivalid      (ireq_valid),
        .dvalid      (dreq_valid),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .owner       (grant_owner)
    );

    assign busy  = (state != IDLE);
    assign grant = (state == IDLE) && grant_valid;

    // Grant FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus response/stall outputs; read data passes straight through.
    always_comb begin
        state_next  = state;
        mem_valid   = busy;
        iresp_valid = (state == IBUS) && mem_ready;
        dresp_valid = (state == DBUS) && mem_ready;
        iresp_data  = '0;
        dresp_data  = '0;
        unique case (state)
            IDLE: begin
                if (grant_valid) state_next = (grant_owner == OWN_D) ? DBUS : IBUS;
            end
            IBUS, DBUS: begin
                if (mem_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (iresp_valid) iresp_data = mem_rdata;
        if (dresp_valid) dresp_data = mem_rdata;
        istall = ireq_valid && !iresp_valid;
        dstall = dreq_valid && !dresp_valid;
    end

    // Capture the granted request; held unchanged for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else if (grant) begin
            if (grant_owner == OWN_D) begin
                mem_addr  <= dreq_addr;
                mem_write <= dreq_write;
                mem_wdata <= dreq_wdata;
            end else begin
                mem_addr  <= ireq_addr;
                mem_write <= 1'b0;
                mem_wdata <= '0;
            end
        end
    end

    // Wait counter and sticky timeout flag; the access is never aborted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (grant) begin
            wait_cnt <= '0;
        end else if (busy && !mem_ready && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_PRESAT) mem_err <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who won the most recent grant.
    always_ff @(posedge clk) begin
        if (reset)      last_owner <= OWN_I;
        else if (grant) last_owner <= grant_owner;
    end
`else
    assign last_owner = OWN_I;
`endif

endmodule
